// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: FSM state encoding and inst bus field positions shared by the core_ctrl files.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QWR,
    ST_KWR,
    ST_KLOAD,
    ST_KFLUSH,
    ST_EXEC,
    ST_DRAIN,
    ST_RDOUT
  } state_e;

  localparam int INST_W     = 17;
  localparam int ADDR_W     = 4;
  localparam int OFIFO_RD   = 16;
  localparam int QK_ADD_LSB = 12;
  localparam int P_ADD_LSB  = 8;
  localparam int EXEC       = 7;
  localparam int KLOAD      = 6;
  localparam int Q_RD       = 5;
  localparam int Q_WR       = 4;
  localparam int K_RD       = 3;
  localparam int K_WR       = 2;
  localparam int P_RD       = 1;
  localparam int P_WR       = 0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/core_ctrl_phase_cnt.sv
// core_ctrl_phase_cnt: loadable up-counter with a terminal-count flag, shared by all
// address and wait phases of core_ctrl.
module core_ctrl_phase_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: one-job-per-start sequencer driving the core inst bus (Q/K write, kernel load,
// execute, OFIFO drain). Define CORE_CTRL_PERF_EN to add the perf_cyc start-to-done counter.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int COL        = 8,
  parameter int MAX_Q      = 16,
  parameter int KFLUSH_CYC = 10,
  parameter int DRAIN_CYC  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_q,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
`ifdef CORE_CTRL_PERF_EN
  ,
  output logic [15:0]       perf_cyc
`endif
);

  // Wait phases and the RDOUT tail (n+2) need more range than the 4-bit addresses.
  localparam int CNT_W = $clog2(max2(max2(DRAIN_CYC, KFLUSH_CYC), max2(MAX_Q + 1, COL)) + 1);

  if (COL < 1 || COL > MAX_Q || MAX_Q > (1 << ADDR_W)) begin : g_param_chk
    $error("core_ctrl: COL must be 1..MAX_Q and MAX_Q must fit the 4-bit address");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic              cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0]  cnt_term, cnt_val;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              done_q, done_d;
  logic              kload_dly_q, exec_dly_q, pwr_dly_q;
  logic [ADDR_W-1:0] padd_q;
  logic              rd_issue;

  core_ctrl_phase_cnt #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (cnt_load),
    .load_val_i ('0),
    .en_i       (cnt_en),
    .term_i     (cnt_term),
    .cnt_o      (cnt_val),
    .tc_o       (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  // Wait states run one cycle past their idle count so the delayed kload/exec tail is not counted.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_term = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_load = 1'b1;
        if (start) begin
          n_d     = num_q;
          state_d = ST_QWR;
        end
      end
      ST_QWR, ST_KWR: begin
        cnt_term = (state_q == ST_QWR) ? CNT_W'(n_q) : CNT_W'(COL - 1);
        if (in_valid) begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            cnt_load = 1'b1;
            state_d  = (state_q == ST_QWR) ? ST_KWR : ST_KLOAD;
          end
        end
      end
      ST_KLOAD, ST_KFLUSH, ST_EXEC, ST_DRAIN, ST_RDOUT: begin
        cnt_en = 1'b1;
        case (state_q)
          ST_KLOAD:  cnt_term = CNT_W'(COL - 1);
          ST_KFLUSH: cnt_term = CNT_W'(KFLUSH_CYC);
          ST_EXEC:   cnt_term = CNT_W'(n_q);
          ST_DRAIN:  cnt_term = CNT_W'(DRAIN_CYC);
          default:   cnt_term = CNT_W'(n_q) + CNT_W'(2);
        endcase
        if (cnt_tc) begin
          cnt_load = 1'b1;
          case (state_q)
            ST_KLOAD:  state_d = ST_KFLUSH;
            ST_KFLUSH: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_DRAIN;
            ST_DRAIN:  state_d = ST_RDOUT;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_issue = (state_q == ST_RDOUT) && (cnt_val <= CNT_W'(n_q));

  always_comb begin
    inst_d        = '0;
    done_d        = 1'b0;
    inst_d[KLOAD] = kload_dly_q;
    inst_d[EXEC]  = exec_dly_q;
    if (pwr_dly_q) begin
      inst_d[P_WR]                  = 1'b1;
      inst_d[P_ADD_LSB +: ADDR_W]   = padd_q;
    end
    case (state_q)
      ST_QWR, ST_KWR: begin
        if (in_valid) begin
          inst_d[(state_q == ST_QWR) ? Q_WR : K_WR] = 1'b1;
          inst_d[QK_ADD_LSB +: ADDR_W]              = cnt_val[ADDR_W-1:0];
        end
      end
      ST_KLOAD, ST_EXEC: begin
        inst_d[(state_q == ST_KLOAD) ? K_RD : Q_RD] = 1'b1;
        inst_d[QK_ADD_LSB +: ADDR_W]                = cnt_val[ADDR_W-1:0];
      end
      ST_RDOUT: begin
        inst_d[OFIFO_RD] = rd_issue;
        done_d           = cnt_tc;
      end
      default: ;
    endcase
  end

  // Registered inst plus the one-cycle SRAM/OFIFO latency stages for kload, exec and p_wr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_q      <= '0;
      done_q      <= 1'b0;
      kload_dly_q <= 1'b0;
      exec_dly_q  <= 1'b0;
      pwr_dly_q   <= 1'b0;
      padd_q      <= '0;
    end else begin
      inst_q      <= inst_d;
      done_q      <= done_d;
      kload_dly_q <= (state_q == ST_KLOAD);
      exec_dly_q  <= (state_q == ST_EXEC);
      pwr_dly_q   <= rd_issue;
      padd_q      <= cnt_val[ADDR_W-1:0];
    end
  end

  assign in_ready = (state_q == ST_QWR) || (state_q == ST_KWR);
  assign busy     = (state_q != ST_IDLE);
  assign inst     = inst_q;
  assign done     = done_q;

`ifdef CORE_CTRL_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Counts from the accept edge, so the value seen with done equals the start-to-done distance.
  always_comb begin
    perf_d = perf_q;
    if (state_q == ST_IDLE) begin
      if (start) perf_d = 16'd1;
    end else if (perf_q != 16'hFFFF) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cyc = perf_q;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: table-driven job vectors plus reset, start-while-busy and start-held sequences.
// Build with CORE_CTRL_PERF_EN defined to also cover perf_cyc.
module tb_core_ctrl;
  import core_ctrl_pkg::*;

  localparam int COL_T  = 8;
  localparam int KFL_T  = 10;
  localparam int DRN_T  = 24;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [3:0]        num_q;
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;
`ifdef CORE_CTRL_PERF_EN
  logic [15:0]       perf_cyc;
`endif

  core_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_q    (num_q),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inst     (inst),
    .busy     (busy),
    .done     (done)
`ifdef CORE_CTRL_PERF_EN
    , .perf_cyc (perf_cyc)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] nq;
    int         vmode;     // 0: in_valid always 1, 1: toggles 1,0,1,0...
    int         pulse;     // cycle at which a stray start is pulsed, -1 for none
    int         exp_done;  // hand-computed done cycle, counted from the accept edge
  } vec_t;

  vec_t vecs[6];

  // Runs one job from start acceptance to done; returns at the negedge of the done cycle
  // (non-hold jobs additionally watch four idle cycles afterwards).
  task automatic run_job(input string tag, input logic [3:0] nq, input int vmode,
                         input int pulse_cyc, input bit hold, input int exp_done,
                         output int done_cyc);
    int cyc, nqi;
    int qwr_n, kwr_n, krd_n, kld_n, qrd_n, exe_n, ofr_n, pwr_n;
    int addr_bad, onehot_bad, hs_bad, busy_bad, post_bad;
    int first_krd, first_kld, last_kld, first_qrd, first_exe, last_exe;
    int first_ofr, first_pwr, last_pwr;
    logic       acc_prev;
    logic [4:0] grp;
    nqi = int'(nq);
    {qwr_n, kwr_n, krd_n, kld_n, qrd_n, exe_n, ofr_n, pwr_n} = '0;
    {addr_bad, onehot_bad, hs_bad, busy_bad, post_bad} = '0;
    {first_krd, first_kld, last_kld, first_qrd, first_exe, last_exe} = {6{-1}};
    {first_ofr, first_pwr, last_pwr} = {3{-1}};
    num_q    = nq;
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    cyc      = 1;
    done_cyc = -1;
    acc_prev = 1'b0;
    while (cyc < 400 && done_cyc < 0) begin
      in_valid = (vmode == 0) ? 1'b1 : logic'(cyc % 2);
      start    = hold | (cyc == pulse_cyc);
      @(negedge clk);
      grp = {inst[Q_WR], inst[K_WR], inst[K_RD] | inst[KLOAD],
             inst[Q_RD] | inst[EXEC], inst[OFIFO_RD] | inst[P_WR]};
      if ($countones(grp) > 1) onehot_bad++;
      if ((inst[Q_WR] | inst[K_WR]) != acc_prev) hs_bad++;
      acc_prev = in_valid & in_ready;
      if (!done && !busy) busy_bad++;
      if (inst[Q_WR]) begin
        if (inst[15:12] != 4'(qwr_n)) addr_bad++;
        qwr_n++;
      end
      if (inst[K_WR]) begin
        if (inst[15:12] != 4'(kwr_n)) addr_bad++;
        kwr_n++;
      end
      if (inst[K_RD]) begin
        if (krd_n == 0) first_krd = cyc;
        else if (cyc != first_krd + krd_n) addr_bad++;
        if (inst[15:12] != 4'(krd_n)) addr_bad++;
        krd_n++;
      end
      if (inst[KLOAD]) begin
        if (kld_n == 0) first_kld = cyc;
        last_kld = cyc;
        kld_n++;
      end
      if (inst[Q_RD]) begin
        if (qrd_n == 0) first_qrd = cyc;
        else if (cyc != first_qrd + qrd_n) addr_bad++;
        if (inst[15:12] != 4'(qrd_n)) addr_bad++;
        qrd_n++;
      end
      if (inst[EXEC]) begin
        if (exe_n == 0) first_exe = cyc;
        last_exe = cyc;
        exe_n++;
      end
      if (inst[OFIFO_RD]) begin
        if (ofr_n == 0) first_ofr = cyc;
        ofr_n++;
      end
      if (inst[P_WR]) begin
        if (pwr_n == 0) first_pwr = cyc;
        if (inst[11:8] != 4'(pwr_n)) addr_bad++;
        last_pwr = cyc;
        pwr_n++;
      end
      if (done) done_cyc = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, " done_cycle"}, done_cyc, exp_done);
    check({tag, " q_wr_count"}, qwr_n, nqi + 1);
    check({tag, " k_wr_count"}, kwr_n, COL_T);
    check({tag, " k_rd_count"}, krd_n, COL_T);
    check({tag, " kload_count"}, kld_n, COL_T);
    check({tag, " kload_offset"}, first_kld, first_krd + 1);
    check({tag, " kflush_idle"}, first_qrd - last_kld - 1, KFL_T);
    check({tag, " q_rd_count"}, qrd_n, nqi + 1);
    check({tag, " exec_count"}, exe_n, nqi + 1);
    check({tag, " exec_offset"}, first_exe, first_qrd + 1);
    check({tag, " drain_idle"}, first_ofr - last_exe - 1, DRN_T);
    check({tag, " ofifo_rd_count"}, ofr_n, nqi + 1);
    check({tag, " p_wr_count"}, pwr_n, nqi + 1);
    check({tag, " p_wr_offset"}, first_pwr, first_ofr + 1);
    check({tag, " done_after_p_wr"}, done_cyc, last_pwr + 1);
    check({tag, " addr_errors"}, addr_bad, 0);
    check({tag, " phase_onehot_errors"}, onehot_bad, 0);
    check({tag, " handshake_errors"}, hs_bad, 0);
    check({tag, " busy_drop_errors"}, busy_bad, 0);
    check({tag, " in_idle_busy"}, int'(busy), 0);
    if (!hold) begin
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (done || busy || inst != '0) post_bad++;
      end
      check({tag, " idle_after_done"}, post_bad, 0);
    end
  endtask

  initial begin
    int dc, seen, bad, cnt;
    vecs[0] = '{nq: 4'd3,  vmode: 0, pulse: -1,  exp_done: 67};
    vecs[1] = '{nq: 4'd3,  vmode: 1, pulse: -1,  exp_done: 78};
    vecs[2] = '{nq: 4'd15, vmode: 0, pulse: -1,  exp_done: 103};
    vecs[3] = '{nq: 4'd0,  vmode: 0, pulse: 2,   exp_done: 58};
    vecs[4] = '{nq: 4'd7,  vmode: 1, pulse: 40,  exp_done: 94};
    vecs[5] = '{nq: 4'd15, vmode: 1, pulse: 100, exp_done: 126};

    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    num_q    = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset inst", int'(inst), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset in_ready", int'(in_ready), 0);
`ifdef CORE_CTRL_PERF_EN
    check("reset perf_cyc", int'(perf_cyc), 0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i].nq, vecs[i].vmode, vecs[i].pulse, 1'b0,
              vecs[i].exp_done, dc);
`ifdef CORE_CTRL_PERF_EN
      check($sformatf("vec%0d perf_cyc", i), int'(perf_cyc), dc);
`endif
    end

    // Reset asserted in the middle of EXEC must abort immediately with no done.
    num_q    = 4'd3;
    in_valid = 1'b1;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen  = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (inst[Q_RD]) seen = 1;
    end
    check("rst_mid reached_exec", seen, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_mid inst", int'(inst), 0);
    check("rst_mid busy", int'(busy), 0);
    check("rst_mid done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done || busy || inst != '0) bad++;
    end
    check("rst_mid no_resume", bad, 0);
    @(posedge clk); #1;
    run_job("post_rst", 4'd3, 0, -1, 1'b0, 67, dc);

    // start held high through done: the next job begins right after IDLE is entered.
    @(posedge clk); #1;
    run_job("hold", 4'd3, 0, -1, 1'b1, 67, dc);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("hold restart_busy", int'(busy), 1);
    cnt = 1;
    while (!done && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      @(negedge clk);
    end
    check("hold second_job_cycles", cnt, 67);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
